// File: rtl/gait_tick_pkg.sv
// gait_tick_pkg: shared config addresses, limits and default-phase helper
// for the gait tick generator.
package gait_tick_pkg;

    localparam int CFG_ADDR_DIV     = 0;
    localparam int CFG_ADDR_PH_BASE = 1;
    localparam int MIN_DIV          = 2;

    // Evenly spread gait phase for channel i of a period of length div.
    function automatic longint default_phase(
        input int     i,
        input longint div,
        input int     channels
    );
        return (longint'(i) * div) / longint'(channels);
    endfunction

endpackage

// File: rtl/gait_tick_chan.sv
// gait_tick_chan: one tick channel - phase shadow/active pair and the
// registered compare. Phase registers exist only with GAIT_TICK_PHASE_EN.
module gait_tick_chan #(
    parameter int DIV_W = 24
`ifdef GAIT_TICK_PHASE_EN
    ,
    parameter logic [DIV_W-1:0] RST_PH = '0
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] cnt,
`ifdef GAIT_TICK_PHASE_EN
    input  logic             wr,
    input  logic             commit,
    input  logic [DIV_W-1:0] data,
`endif
    output logic             tick
);

`ifdef GAIT_TICK_PHASE_EN
    logic [DIV_W-1:0] ph_act;
    logic [DIV_W-1:0] ph_shd;

    // Commit takes the pre-write shadow; a same-cycle write waits a period.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph_act <= RST_PH;
            ph_shd <= RST_PH;
        end else begin
            if (commit)
                ph_act <= ph_shd;
            if (wr)
                ph_shd <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            tick <= 1'b0;
        else
            tick <= en && (cnt == ph_act);
    end
`else
    always_ff @(posedge clk) begin
        if (reset)
            tick <= 1'b0;
        else
            tick <= en && (cnt == '0);
    end
`endif

endmodule

// File: rtl/gait_tick_gen.sv
// gait_tick_gen: shared period counter driving per-channel phased ticks.
// Per-channel phases are built only when GAIT_TICK_PHASE_EN is defined.
module gait_tick_gen
    import gait_tick_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int DIV_W       = 24,
    parameter  int DEFAULT_DIV = 12000000,
    localparam int AW          = $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [DIV_W-1:0]    cfg_data,
    output logic [CHANNELS-1:0] tick,
    output logic                period_start
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_shd;
    logic             div_pend;
    logic             accept;
    logic             div_wr;
    logic             wrap;
    logic             commit;

    assign cfg_ready = !div_pend;
    assign accept    = cfg_valid && cfg_ready;
    assign div_wr    = accept && (cfg_addr == AW'(CFG_ADDR_DIV));
    assign wrap      = en && (cnt == div_act - ONE);
    // Disabled periods are boundaries too, so config lands while idle.
    assign commit    = wrap || !en;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            div_act      <= DEF_DIV;
            div_shd      <= DEF_DIV;
            div_pend     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= commit ? '0 : cnt + ONE;
            period_start <= en && (cnt == '0);
            if (commit)
                div_act <= div_shd;
            if (div_wr)
                div_shd <= (cfg_data < MIN_D) ? MIN_D : cfg_data;
            div_pend <= div_wr || (div_pend && !commit);
        end
    end

`ifdef GAIT_TICK_PHASE_EN
    logic ph_pend;
    logic ph_wr_any;

    assign ph_wr_any = accept
                    && (int'(cfg_addr) >= CFG_ADDR_PH_BASE)
                    && (int'(cfg_addr) < CFG_ADDR_PH_BASE + CHANNELS);

    always_ff @(posedge clk) begin
        if (reset)
            ph_pend <= 1'b0;
        else
            ph_pend <= ph_wr_any || (ph_pend && !commit);
    end
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
`ifdef GAIT_TICK_PHASE_EN
        gait_tick_chan #(
            .DIV_W  (DIV_W),
            .RST_PH (DIV_W'(default_phase(i, longint'(DEFAULT_DIV),
                                          CHANNELS)))
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .cnt    (cnt),
            .wr     (accept && (cfg_addr == AW'(CFG_ADDR_PH_BASE + i))),
            .commit (commit && ph_pend),
            .data   (cfg_data),
            .tick   (tick[i])
        );
`else
        gait_tick_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .cnt   (cnt),
            .tick  (tick[i])
        );
`endif
    end

endmodule

// File: tb/tb_gait_tick_gen.sv
// tb_gait_tick_gen: directed bench with a period-level reference model
// and hand-computed tick timelines for the gait tick generator.
module tb_gait_tick_gen;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int DEF = 8;
`ifdef GAIT_TICK_PHASE_EN
    localparam bit PH = 1'b1;
`else
    localparam bit PH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [2:0]    cfg_addr = '0;
    logic [W-1:0]  cfg_data = '0;
    logic [CH-1:0] tick;
    logic          period_start;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    gait_tick_gen #(
        .CHANNELS    (CH),
        .DIV_W       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .tick         (tick),
        .period_start (period_start)
    );

    task automatic chk(input string nm, input logic [5:0] act,
                       input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    // Reference model: position in period, active/shadow settings.
    int            m_cnt, m_div, m_dshd;
    bit            m_dpend;
    bit            m_valid = 1'b0;
    int            m_ph[CH];
    int            m_pshd[CH];
    logic [CH-1:0] m_tick;
    logic          m_ps;

    initial begin : model
        bit acc, bound;
        int nxt;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_cnt = 0; m_div = DEF; m_dshd = DEF; m_dpend = 0;
                m_tick = '0; m_ps = 1'b0; m_valid = 1'b1;
                for (int i = 0; i < CH; i++) begin
                    m_ph[i] = PH ? (i * DEF) / CH : 0;
                    m_pshd[i] = m_ph[i];
                end
            end else begin
                acc  = cfg_valid && !m_dpend;
                m_ps = en && (m_cnt == 0);
                for (int i = 0; i < CH; i++)
                    m_tick[i] = en && (m_cnt == m_ph[i]);
                bound = !en || (m_cnt == m_div - 1);
                nxt   = bound ? 0 : m_cnt + 1;
                if (bound) begin
                    m_div = m_dshd;
                    for (int i = 0; i < CH; i++) m_ph[i] = m_pshd[i];
                    m_dpend = 0;
                end
                if (acc) begin
                    if (cfg_addr == 0) begin
                        m_dshd = (cfg_data < 2) ? 2 : int'(cfg_data);
                        m_dpend = 1;
                    end else if (PH && int'(cfg_addr) <= CH) begin
                        m_pshd[int'(cfg_addr) - 1] = int'(cfg_data);
                    end
                end
                m_cnt = nxt;
            end
        end
    end

    initial begin : cycle_count
        forever begin
            @(posedge clk);
            cyc = reset ? 0 : cyc + 1;
        end
    end

    logic [4:0] log_pt[128];
    logic       log_rdy[128];

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("cycle", {cfg_ready, period_start, tick},
                    {!m_dpend, m_ps, m_tick});
                log_pt[cyc % 128]  = {period_start, tick};
                log_rdy[cyc % 128] = cfg_ready;
            end
        end
    end

    task automatic lit_pt(input int c, input logic [4:0] exp);
        chk($sformatf("pt@%0d", c), {1'b0, log_pt[c]}, {1'b0, exp});
    endtask

    task automatic lit_rdy(input int c, input logic exp);
        chk($sformatf("rdy@%0d", c), {5'b0, log_rdy[c]}, {5'b0, exp});
    endtask

    task automatic at_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cyc != c) begin
            checks++;
            failures++;
            $display("FAIL at_cyc got=%0d want=%0d", cyc, c);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [W-1:0] d);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        while (!cfg_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cfg_ready) begin
            failures++;
            $display("FAIL cfg_write ready got=0 want=1");
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    // Expected {period_start, tick[3:0]} patterns.
    localparam logic [4:0] P_C0   = PH ? 5'b10001 : 5'b11111;
    localparam logic [4:0] P_C01  = PH ? 5'b10011 : 5'b11111;
    localparam logic [4:0] P_T1   = PH ? 5'b00010 : 5'b00000;
    localparam logic [4:0] P_T2   = PH ? 5'b00100 : 5'b00000;
    localparam logic [4:0] P_T3   = PH ? 5'b01000 : 5'b00000;
    localparam logic [4:0] P_NONE = 5'b00000;

    initial begin : stim
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Divisor 4 at cnt=2, then a held second write of 6.
        at_cyc(18);
        cfg_write(3'd0, 8'd4);
        cfg_write(3'd0, 8'd6);

        // Divisor 0 clamps to 2.
        at_cyc(40);
        cfg_write(3'd0, 8'd0);

        // Back to 8, then move ch1 onto phase 0.
        at_cyc(50);
        cfg_write(3'd0, 8'd8);
        at_cyc(53);
        cfg_write(3'd2, 8'd0);

        // en low for 5 cycles with a divisor write.
        at_cyc(69);
        en = 1'b0;
        at_cyc(70);
        cfg_write(3'd0, 8'd5);
        at_cyc(74);
        en = 1'b1;

        // Pending write then reset mid-period.
        at_cyc(86);
        cfg_write(3'd0, 8'd3);
        at_cyc(88);

        lit_pt(1, P_C0);   lit_pt(2, P_NONE); lit_pt(3, P_T1);
        lit_pt(5, P_T2);   lit_pt(7, P_T3);   lit_pt(9, P_C0);
        lit_pt(17, P_C0);
        lit_rdy(18, 1'b1); lit_rdy(19, 1'b0); lit_rdy(23, 1'b0);
        lit_rdy(24, 1'b1); lit_rdy(25, 1'b0); lit_rdy(28, 1'b1);
        lit_pt(25, P_C0);  lit_pt(27, P_T1);  lit_pt(29, P_C0);
        lit_pt(31, P_T1);  lit_pt(33, P_T2);  lit_pt(35, P_C0);
        lit_rdy(41, 1'b0); lit_rdy(46, 1'b1);
        lit_pt(46, P_NONE); lit_pt(47, P_C0); lit_pt(48, P_NONE);
        lit_pt(49, P_C0);
        lit_pt(53, P_C0);  lit_rdy(54, 1'b1); lit_pt(55, P_T1);
        lit_pt(57, P_T2);  lit_pt(61, P_C01); lit_pt(63, P_NONE);
        lit_pt(69, P_C01);
        for (int c = 70; c <= 74; c++) lit_pt(c, P_NONE);
        lit_rdy(71, 1'b0); lit_rdy(72, 1'b1);
        lit_pt(75, P_C01); lit_pt(77, P_NONE); lit_pt(79, P_T2);
        lit_pt(80, P_C01);
        lit_rdy(87, 1'b0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        at_cyc(20);

        lit_rdy(0, 1'b1);  lit_pt(0, P_NONE); lit_pt(1, P_C0);
        lit_rdy(2, 1'b1);  lit_pt(3, P_T1);   lit_pt(4, P_NONE);
        lit_pt(9, P_C0);   lit_pt(17, P_C0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gait_tick_gen.md
# gait_tick_gen

Multi-channel, runtime-programmable tick generator for gait timing. It replaces fixed-frequency single-output heartbeat dividers. One shared period counter drives CHANNELS single-cycle tick outputs, each at its own programmable phase offset within the period. The controller core reprograms the period and phases through a valid/ready config port. New values take effect only on period boundaries, so the servo sequencers never see a runt or doubled tick.

## Interface
- CHANNELS, 4: number of tick outputs (1..16).
- DIV_W, 24: width of the period counter, divisor and phase registers.
- DEFAULT_DIV, 12000000: period in clk cycles after reset (1 Hz at 12 MHz).
- AW, $clog2(CHANNELS+1): config address width (localparam).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  run enable; low holds the counter at 0.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_addr  in  AW  0 = divisor; k in 1..CHANNELS = phase of channel k-1; larger values are ignored.
- cfg_data  in  DIV_W  write data.
- tick  out  CHANNELS  one-cycle pulse per channel per period.
- period_start  out  1  one-cycle pulse when the counter passes 0.

## Operation
- Registers:
  - cnt: the period counter.
  - div_act and div_shd: active and shadow divisor.
  - ph_act[i] and ph_shd[i]: active and shadow phase for each channel.
  - div_pend: divisor commit pending.
  - ph_pend: phase commit pending.
- Reset values:
  - cnt = 0.
  - div_act = div_shd = DEFAULT_DIV.
  - ph_act[i] = ph_shd[i] = (i*DEFAULT_DIV)/CHANNELS, giving evenly spread gait phases.
  - div_pend = ph_pend = 0.
  - tick = 0, period_start = 0, cfg_ready = 1.
- Counter:
  - When en = 1: cnt increments each cycle. When cnt == div_act-1 it wraps to 0; this is the "wrap" event.
  - When en = 0: cnt is forced to 0 and no ticks are produced.
- Ticks:
  - tick[i] is registered and is high in cycle t+1 when, in cycle t, en = 1 and cnt == ph_act[i].
  - period_start is registered and is high in cycle t+1 when, in cycle t, en = 1 and cnt == 0.
- Config accept:
  - A write is accepted when cfg_valid & cfg_ready.
  - Divisor write: div_shd <= max(cfg_data, 2), and div_pend is set.
  - Phase write: ph_shd[k-1] <= cfg_data, and ph_pend is set.
  - A write to an out-of-range address is accepted and has no effect.
- cfg_ready = !div_pend. A second divisor write stalls until the first commits. A phase write issued while div_pend is set also stalls.
- Commit:
  - On a wrap cycle, or on any cycle with en = 0, the active registers load from the shadows and both pend flags clear.
  - On a wrap cycle, cnt goes to 0 in the same edge and the new values govern from cnt = 0 onward.
- Accept and commit in the same cycle: the accepted data is written into the shadow and commits on the next boundary, not the current one. The pend flag stays set.
- A phase with ph_act[i] >= div_act never matches, so that channel is silent. This is legal.
- Reset mid-period: all state returns to the reset values on the next edge and any pending writes are discarded.

## Timing
- Release reset with en = 1 at cycle 0 (cnt = 0). tick[0] and period_start are first high in cycle 1, then every div_act cycles.
- Tick latency from the matching counter value is 1 cycle.
- Minimum effective divisor is 2, so the maximum tick rate is clk/2.
- Divisor write latency: from accept to new period is at most old div_act cycles, plus 1 cycle for an en-low commit.
- en falling edge: the counter is 0 on the next cycle. A tick already registered from the last en-high cycle still appears. No ticks follow after that.

## Configuration
- GAIT_TICK_PHASE_EN defined:
  - Per-channel phase registers exist and behave as above.
- GAIT_TICK_PHASE_EN undefined:
  - ph_act and ph_shd are removed and every channel uses phase 0, so all ticks equal period_start.
  - Phase writes are accepted and discarded, and ph_pend is not implemented.

## Structure
- Package gait_tick_pkg:
  - CFG_ADDR_DIV = 0 and CFG_ADDR_PH_BASE = 1.
  - MIN_DIV = 2.
  - The default-phase function (i*div)/channels.
- Sub-module gait_tick_chan, one per channel:
  - Holds the phase shadow and active registers, the commit logic, and the compare-and-register tick.
  - Top level owns the counter, divisor, pend flags and config decode.

## Test plan
All cases use DEFAULT_DIV = 8, CHANNELS = 4, DIV_W = 8.
- Reset release, en = 1 -> period_start at cycles 1, 9, 17; tick[0..3] at cycles 1, 3, 5, 7 (mod 8).
- Divisor write of 4 accepted at cnt = 2 -> cfg_ready low until the wrap. The next period is 4 cycles long. A second divisor write presented meanwhile is held until cfg_ready rises.
- Divisor write of 0 -> behaves as divisor 2, ticking every 2 cycles. With phases 4 and 6 at divisor 2, tick[2] and tick[3] stay silent.
- Phase write of ch1 = 0 with the divisor unchanged -> tick[1] moves onto period_start starting from the next period. The remainder of the current period is unchanged.
- Drop en for 5 cycles, write divisor 5, raise en -> the commit happens while en is low. The first tick[0] comes 1 cycle after en rises, with a period of 5. No ticks occur while en is low, apart from one already registered.
- Assert reset mid-period with a divisor write pending -> returns to DEFAULT_DIV timing with cfg_ready = 1. The pending write is lost.
- With GAIT_TICK_PHASE_EN undefined -> all four ticks coincide with period_start every 8 cycles.
